// File: rtl/param_shift_register.sv
// WIDTH-bit universal shift register with a counted-rotate sequencer (BUSY/DONE handshake).
// Each Q bit lives in its own cell; the top only decides which neighbour every cell takes.

package psr_pkg;
  typedef enum logic [1:0] {SEL_KEEP, SEL_LO, SEL_HI, SEL_LOAD} sel_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} seq_e;
  typedef enum logic [2:0] {
    M_HOLD    = 3'b000,
    M_SHIFT   = 3'b001,
    M_CIRC    = 3'b010,
    M_LOAD    = 3'b011,
    M_ARITH   = 3'b100,
    M_COUNTED = 3'b101
  } mode_e;

  // Per-edge move request shared by every bit cell
  typedef struct packed {
    sel_e sel;
    logic fill_lo;   // bit entering Q[0] on a left move
    logic fill_hi;   // bit entering Q[W-1] on a right move
    logic so_upd;
    logic so_val;
  } shift_ctl_t;
endpackage

module psr_bit_cell
  import psr_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en,
  input  logic [1:0] sel,
  input  logic       lo_in,
  input  logic       hi_in,
  input  logic       d_in,
  output logic       q
);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q <= 1'b0;
    end else if (en) begin
      case (sel)
        SEL_LO:   q <= lo_in;
        SEL_HI:   q <= hi_in;
        SEL_LOAD: q <= d_in;
        default:  q <= q;
      endcase
    end
  end
endmodule

module param_shift_register
  import psr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [2:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [CNT_W-1:0] CNT,
  input  logic             START,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE
);
  seq_e             state, state_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             dir_l, dir_nxt;
  shift_ctl_t       ctl;
  logic [WIDTH-1:0] lo_nb, hi_nb;
  logic             so_dir, so_run;

  // Bit leaving the register for a one-position move; for rotates it is also the wrap-in bit
  assign so_dir = DIR   ? Q[0] : Q[WIDTH-1];
  assign so_run = dir_l ? Q[0] : Q[WIDTH-1];

  function automatic shift_ctl_t mv(input logic right, input logic fill, input logic so);
    mv = '{sel: (right ? SEL_HI : SEL_LO), fill_lo: fill, fill_hi: fill,
           so_upd: 1'b1, so_val: so};
  endfunction

  always_comb begin
    ctl       = '{sel: SEL_KEEP, fill_lo: 1'b0, fill_hi: 1'b0, so_upd: 1'b0, so_val: 1'b0};
    state_nxt = state;
    rem_nxt   = rem;
    dir_nxt   = dir_l;
    if (state == ST_RUN) begin
      // Mode inputs are ignored while a counted rotate is in flight
      ctl     = mv(dir_l, so_run, so_run);
      rem_nxt = rem - CNT_W'(1);
      if (rem == CNT_W'(1)) state_nxt = ST_FIN;
    end else begin
      if (state == ST_FIN) state_nxt = ST_IDLE;
      case (MODO)
        M_SHIFT:   ctl = mv(DIR, S_IN, so_dir);
        M_CIRC:    ctl = mv(DIR, so_dir, so_dir);
        M_LOAD:    ctl.sel = SEL_LOAD;
        M_ARITH:   ctl = mv(DIR, DIR ? Q[WIDTH-1] : 1'b0, so_dir);
        M_COUNTED: begin
          // FIN does not accept a new start; it only drains back to IDLE
          if (START && state == ST_IDLE) begin
            if (CNT != '0) begin
              state_nxt = ST_RUN;
              rem_nxt   = CNT;
              dir_nxt   = DIR;
            end else begin
              state_nxt = ST_FIN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign lo_nb = {Q[WIDTH-2:0], ctl.fill_lo};
  assign hi_nb = {ctl.fill_hi, Q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    psr_bit_cell u_cell (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (ENB),
      .sel   (ctl.sel),
      .lo_in (lo_nb[i]),
      .hi_in (hi_nb[i]),
      .d_in  (D[i]),
      .q     (Q[i])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      rem   <= '0;
      dir_l <= 1'b0;
      S_OUT <= 1'b0;
    end else if (ENB) begin
      state <= state_nxt;
      rem   <= rem_nxt;
      dir_l <= dir_nxt;
      if (ctl.so_upd) S_OUT <= ctl.so_val;
    end
  end

  // Flags decode the registered state, so a stalled FIN keeps DONE high
  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_FIN);
endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model built from plain shift/rotate arithmetic.

module tb_param_shift_register;
  localparam int W  = 4;
  localparam int CW = 4;

  logic          CLK = 1'b0, RST_N = 1'b0, ENB = 1'b0, DIR = 1'b0, S_IN = 1'b0, START = 1'b0;
  logic [2:0]    MODO = '0;
  logic [W-1:0]  D = '0;
  logic [CW-1:0] CNT = '0;
  logic [W-1:0]  Q;
  logic          S_OUT, BUSY, DONE;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  param_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO),
    .D(D), .CNT(CNT), .START(START), .Q(Q), .S_OUT(S_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    int k;
    k = n % W;
    return (v << k) | (v >> (W - k));
  endfunction

  // Behavioural model: a rotate counter and two flags instead of a state machine
  logic [W-1:0] m_q = '0;
  logic         m_so = 1'b0;
  bit           m_busy = 1'b0, m_done = 1'b0, m_dir = 1'b0, m_was_done = 1'b0;
  int           m_left = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_q = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_dir = 1'b0;
    end else if (ENB) begin
      if (m_busy) begin
        m_so = m_dir ? m_q[0] : m_q[W-1];
        m_q  = rotl(m_q, m_dir ? W - 1 : 1);
        m_left--;
        if (m_left == 0) begin m_busy = 1'b0; m_done = 1'b1; end
      end else begin
        m_was_done = m_done;
        m_done = 1'b0;
        case (MODO)
          3'd1: begin
            m_so = DIR ? m_q[0] : m_q[W-1];
            m_q  = DIR ? ((m_q >> 1) | (W'(S_IN) << (W - 1))) : ((m_q << 1) | W'(S_IN));
          end
          3'd2: begin
            m_so = DIR ? m_q[0] : m_q[W-1];
            m_q  = rotl(m_q, DIR ? W - 1 : 1);
          end
          3'd3: m_q = D;
          3'd4: begin
            m_so = DIR ? m_q[0] : m_q[W-1];
            if (DIR) m_q = $signed(m_q) >>> 1;
            else     m_q = m_q << 1;
          end
          3'd5: begin
            if (START && !m_was_done) begin
              if (CNT == '0) m_done = 1'b1;
              else begin m_busy = 1'b1; m_left = int'(CNT); m_dir = DIR; end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_q", 32'(Q), 32'(m_q));
      check("model_s_out", 32'(S_OUT), 32'(m_so));
      check("model_busy", 32'(BUSY), 32'(m_busy));
      check("model_done", 32'(DONE), 32'(m_done));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    ENB = 1'b1; MODO = 3'd3; D = v; START = 1'b0;
    tick();
  endtask

  // Launch a counted rotate from start_q; ENB drops for stall_len edges starting at edge stall_at
  task automatic run_counted(input logic [W-1:0] start_q, input logic [CW-1:0] k, input logic d,
                             input int stall_at, input int stall_len,
                             output int edges, output int busy_n, output logic [W-1:0] q_done);
    load(start_q);
    MODO = 3'd5; CNT = k; DIR = d; START = 1'b1;
    tick();
    START = 1'b0; MODO = 3'd3; D = '1; DIR = ~d; S_IN = 1'b1;
    edges = 0;
    busy_n = BUSY ? 1 : 0;
    while (DONE !== 1'b1 && edges < 64) begin
      ENB = !(edges >= stall_at && edges < stall_at + stall_len);
      tick();
      edges++;
      if (BUSY === 1'b1) busy_n++;
    end
    q_done = Q;
    ENB = 1'b1; MODO = 3'd0;
  endtask

  logic [W-1:0] circ_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic         circ_so  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int edges, busy_n, done_seen;
    logic [W-1:0] qd;

    repeat (2) tick();
    chk_en = 1'b1;
    RST_N = 1'b1; ENB = 1'b1;

    // Asynchronous reset from a non-zero register
    load(4'b1010);
    check("load_1010", 32'(Q), 32'(4'b1010));
    MODO = 3'd0;
    RST_N = 1'b0;
    #1;
    check("rst_async_q", 32'(Q), 0);
    check("rst_async_s_out", 32'(S_OUT), 0);
    check("rst_async_busy", 32'(BUSY), 0);
    check("rst_async_done", 32'(DONE), 0);
    tick();
    RST_N = 1'b1;

    load(4'b1000);
    MODO = 3'd2; DIR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("circ_left_q", 32'(Q), 32'(circ_exp[i]));
      check("circ_left_s_out", 32'(S_OUT), 32'(circ_so[i]));
    end

    load(4'b0110);
    MODO = 3'd1; DIR = 1'b1; S_IN = 1'b1;
    tick();
    check("shift_right_q1", 32'(Q), 32'(4'b1011));
    check("shift_right_so1", 32'(S_OUT), 0);
    tick();
    check("shift_right_q2", 32'(Q), 32'(4'b1101));
    check("shift_right_so2", 32'(S_OUT), 1);

    load(4'b1001);
    MODO = 3'd4; DIR = 1'b1;
    tick();
    check("arith_right_q1", 32'(Q), 32'(4'b1100));
    tick();
    check("arith_right_q2", 32'(Q), 32'(4'b1110));
    DIR = 1'b0;
    tick();
    check("arith_left_q", 32'(Q), 32'(4'b1100));
    check("arith_left_so", 32'(S_OUT), 1);

    run_counted(4'b0001, 4'd6, 1'b0, 0, 0, edges, busy_n, qd);
    check("cnt6_edges", 32'(edges), 6);
    check("cnt6_busy_cycles", 32'(busy_n), 6);
    check("cnt6_q", 32'(qd), 32'(4'b0100));
    tick();
    check("cnt6_done_pulse", 32'(DONE), 0);

    run_counted(4'b0001, 4'd6, 1'b0, 2, 2, edges, busy_n, qd);
    check("cnt6_stall_edges", 32'(edges), 8);
    check("cnt6_stall_busy_cycles", 32'(busy_n), 8);
    check("cnt6_stall_q", 32'(qd), 32'(4'b0100));
    ENB = 1'b0;
    tick();
    check("fin_stalled_done", 32'(DONE), 1);
    ENB = 1'b1;
    tick();
    check("fin_released_done", 32'(DONE), 0);

    run_counted(4'b0001, 4'd9, 1'b1, 0, 0, edges, busy_n, qd);
    check("cnt9_right_edges", 32'(edges), 9);
    check("cnt9_right_q", 32'(qd), 32'(4'b1000));
    tick();

    load(4'b0101);
    MODO = 3'd5; CNT = '0; START = 1'b1;
    tick();
    check("cnt0_busy", 32'(BUSY), 0);
    check("cnt0_done", 32'(DONE), 1);
    check("cnt0_q", 32'(Q), 32'(4'b0101));
    START = 1'b0; MODO = 3'd0;
    tick();
    check("cnt0_done_clear", 32'(DONE), 0);

    load(4'b0011);
    MODO = 3'd5; CNT = 4'd5; DIR = 1'b0; START = 1'b1;
    tick();
    START = 1'b0; MODO = 3'd0;
    tick();
    check("run_busy_before_rst", 32'(BUSY), 1);
    RST_N = 1'b0;
    #1;
    check("rst_run_q", 32'(Q), 0);
    check("rst_run_busy", 32'(BUSY), 0);
    check("rst_run_done", 32'(DONE), 0);
    tick();
    RST_N = 1'b1;
    done_seen = 0;
    repeat (8) begin
      tick();
      if (DONE !== 1'b0) done_seen++;
    end
    check("rst_run_no_done", 32'(done_seen), 0);

    for (int n = 0; n < 4000; n++) begin
      ENB   = ($urandom_range(0, 9) != 0);
      MODO  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) MODO = 3'd5;
      DIR   = 1'($urandom);
      S_IN  = 1'($urandom);
      D     = W'($urandom);
      START = ($urandom_range(0, 2) == 0);
      CNT   = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
